lane_render_ctrl: RTL and testbench

Parametrised frame-sequencing controller for the note highway. It drives NUM_LANES falling-note lanes through a fixed cycle: shift the note registers, draw every occupied lane, wait for the beat, then erase every occupied lane. Each draw or erase is one handshaked operation with the downstream sprite plotter. Compared with the single-lane controller, it adds per-lane sequencing, empty-lane skipping, pause/stop control, beat latching with overrun detection, and a frame counter.

---
 rtl/lane_render_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_lane_render_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_render_ctrl.sv
// lane_render_ctrl: frame sequencer for the note highway.
// Each frame shifts the note registers, draws every occupied lane, waits for
// a beat, then erases every occupied lane. Each lane draw/erase is a single
// plot_go / plot_done handshake with the sprite plotter. Supports pause,
// stop (never abandons the plotter mid-sprite), beat latching with overrun
// flagging, and a frame counter.
module lane_render_ctrl #(
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned LANE_W    = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_i,
  input  logic                 start_i,
  input  logic                 pause_i,
  input  logic                 stop_i,
  input  logic                 plot_done_i,
  input  logic [NUM_LANES-1:0] lane_active_i,
  output logic                 shift_o,
  output logic                 plot_go_o,
  output logic                 plot_erase_o,
  output logic [LANE_W-1:0]    lane_sel_o,
  output logic                 busy_o,
  output logic                 paused_o,
  output logic                 overrun_o,
  output logic [CNT_W-1:0]     beat_count_o
);

  // Lane mask padded to the full lane_sel range so indexing is always in range.
  localparam int unsigned        SEL_N     = 1 << LANE_W;
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic               PH_DRAW   = 1'b0;
  localparam logic               PH_ERASE  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ISSUE,
    S_OP,
    S_NEXT,
    S_WAIT,
    S_PAUSED
  } state_t;

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [LANE_W-1:0]   lane_sel_q, lane_sel_d;
  logic                beat_pend_q, beat_pend_d;
  logic                stop_req_q, stop_req_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                shift_q, shift_d;
  logic                plot_go_q, plot_go_d;
  logic                busy_q, busy_d;
  logic                paused_q, paused_d;

  logic [SEL_N-1:0]    lane_pad;
  logic                lane_hit;
  logic                active_st;

  assign lane_pad  = SEL_N'(lane_active_i);
  assign lane_hit  = lane_pad[lane_sel_q];
  // States in which beats are latched and stop is deferred until the lane op ends.
  assign active_st = (state_q == S_SHIFT) || (state_q == S_ISSUE) ||
                     (state_q == S_OP)    || (state_q == S_NEXT);

  // State and registered-output update; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_DRAW;
      lane_sel_q  <= '0;
      beat_pend_q <= 1'b0;
      stop_req_q  <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= 1'b0;
      plot_go_q   <= 1'b0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      lane_sel_q  <= lane_sel_d;
      beat_pend_q <= beat_pend_d;
      stop_req_q  <= stop_req_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      plot_go_q   <= plot_go_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
    end
  end

  // Next-state, beat/stop latching and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    lane_sel_d  = lane_sel_q;
    beat_pend_d = beat_pend_q;
    stop_req_d  = stop_req_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    shift_d     = 1'b0;
    plot_go_d   = 1'b0;
    busy_d      = 1'b0;
    paused_d    = 1'b0;

    // A beat while the sequence is running is remembered; a second one is lost.
    if (active_st) begin
      if (beat_i) begin
        if (beat_pend_q) begin
          overrun_d = 1'b1;
        end
        beat_pend_d = 1'b1;
      end
      if (stop_i) begin
        stop_req_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!stop_i && start_i) begin
          overrun_d = 1'b0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (lane_hit) begin
          plot_go_d = 1'b1;
          state_d   = S_OP;
        end else begin
          state_d = S_NEXT;
        end
      end

      S_OP: begin
        if (plot_done_i) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (stop_req_q) begin
          state_d = S_IDLE;
        end else if (lane_sel_q < LAST_LANE) begin
          lane_sel_d = lane_sel_q + LANE_W'(1);
          state_d    = S_ISSUE;
        end else if (phase_q == PH_ERASE) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A stop that landed on the final NEXT is honoured here.
        if (stop_i || stop_req_q) begin
          state_d = S_IDLE;
        end else if (pause_i) begin
          state_d = S_PAUSED;
          if (beat_i) begin
            if (beat_pend_q) begin
              overrun_d = 1'b1;
            end
            beat_pend_d = 1'b1;
          end
        end else if (beat_i || beat_pend_q) begin
          // A fresh beat arriving while a latched one is consumed stays pending.
          beat_pend_d = beat_i & beat_pend_q;
          phase_d     = PH_ERASE;
          lane_sel_d  = '0;
          state_d     = S_ISSUE;
        end
      end

      S_PAUSED: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (!pause_i) begin
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entering SHIFT starts a new frame in the draw phase from lane 0.
    if (state_d == S_SHIFT) begin
      shift_d    = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
      phase_d    = PH_DRAW;
      lane_sel_d = '0;
    end

    // Nothing carries over into IDLE: no stale stop request or beat.
    if (state_d == S_IDLE) begin
      stop_req_d  = 1'b0;
      beat_pend_d = 1'b0;
    end

    busy_d   = (state_d != S_IDLE) && (state_d != S_PAUSED);
    paused_d = (state_d == S_PAUSED);
  end

  assign shift_o      = shift_q;
  assign plot_go_o    = plot_go_q;
  assign plot_erase_o = phase_q;
  assign lane_sel_o   = lane_sel_q;
  assign busy_o       = busy_q;
  assign paused_o     = paused_q;
  assign overrun_o    = overrun_q;
  assign beat_count_o = cnt_q;

endmodule

// File: tb/tb_lane_render_ctrl.sv
// Bench for lane_render_ctrl: directed frames, a model plotter that answers
// plot_go with plot_done three cycles later, and a scoreboard of expected
// plotter operations and frame counts checked by an independent monitor.
module tb_lane_render_ctrl;

  logic        clk;
  logic        reset;
  logic        beat_i;
  logic        start_i;
  logic        pause_i;
  logic        stop_i;
  logic        plot_done_i;
  logic [4:0]  lane_active_i;
  logic        shift_o;
  logic        plot_go_o;
  logic        plot_erase_o;
  logic [2:0]  lane_sel_o;
  logic        busy_o;
  logic        paused_o;
  logic        overrun_o;
  logic [15:0] beat_count_o;

  typedef struct packed {
    logic [2:0] lane;
    logic       erase;
  } op_t;

  op_t         op_q[$];
  int unsigned cnt_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  lane_render_ctrl #(
    .NUM_LANES(5),
    .LANE_W   (3),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .beat_i       (beat_i),
    .start_i      (start_i),
    .pause_i      (pause_i),
    .stop_i       (stop_i),
    .plot_done_i  (plot_done_i),
    .lane_active_i(lane_active_i),
    .shift_o      (shift_o),
    .plot_go_o    (plot_go_o),
    .plot_erase_o (plot_erase_o),
    .lane_sel_o   (lane_sel_o),
    .busy_o       (busy_o),
    .paused_o     (paused_o),
    .overrun_o    (overrun_o),
    .beat_count_o (beat_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_shift"},    32'(shift_o),      32'd0);
    check({tag, "_plot_go"},  32'(plot_go_o),    32'd0);
    check({tag, "_erase"},    32'(plot_erase_o), 32'd0);
    check({tag, "_lane_sel"}, 32'(lane_sel_o),   32'd0);
    check({tag, "_busy"},     32'(busy_o),       32'd0);
    check({tag, "_paused"},   32'(paused_o),     32'd0);
    check({tag, "_overrun"},  32'(overrun_o),    32'd0);
    check({tag, "_count"},    32'(beat_count_o), 32'd0);
  endtask

  task automatic wait_shift(input string name, input int bound);
    int n = 0;
    while (!shift_o && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(shift_o), 32'd1);
  endtask

  task automatic wait_go(input string name, input int bound);
    int n = 0;
    while (!plot_go_o && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(plot_go_o), 32'd1);
  endtask

  task automatic push_op(input logic [2:0] lane, input logic erase);
    op_t o;
    o.lane  = lane;
    o.erase = erase;
    op_q.push_back(o);
  endtask

  // Model plotter: plot_done pulses three cycles after each plot_go.
  initial begin
    int cnt = 0;
    plot_done_i = 1'b0;
    forever begin
      tick();
      plot_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) plot_done_i = 1'b1;
      end
      if (plot_go_o) cnt = 3;
    end
  end

  // Monitor: pops expectations whenever the DUT issues an operation or a shift.
  initial begin
    op_t         e;
    int unsigned ec;
    logic [2:0]  hold_lane = '0;
    logic        hold_erase = 1'b0;
    logic        hold_act = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_act = 1'b0;
      end else begin
        if (plot_go_o) begin
          if (op_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_plot_go: lane %0d erase %0d, none expected", lane_sel_o, plot_erase_o);
          end else begin
            e = op_q.pop_front();
            check("plot_lane",  32'(lane_sel_o),   32'(e.lane));
            check("plot_erase", 32'(plot_erase_o), 32'(e.erase));
            hold_lane  = e.lane;
            hold_erase = e.erase;
            hold_act   = 1'b1;
          end
        end
        if (plot_done_i && hold_act) begin
          check("hold_lane",  32'(lane_sel_o),   32'(hold_lane));
          check("hold_erase", 32'(plot_erase_o), 32'(hold_erase));
          hold_act = 1'b0;
        end
        if (shift_o) begin
          if (cnt_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_shift: beat_count %0d, none expected", beat_count_o);
          end else begin
            ec = cnt_q.pop_front();
            check("frame_count", 32'(beat_count_o), 32'(ec));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start_i = 1'b1;
    beat_i = 1'b0;
    pause_i = 1'b0;
    stop_i = 1'b0;
    lane_active_i = 5'b10101;

    // Reset held with start high: everything quiet.
    repeat (3) tick();
    check_reset_state("reset");

    // Frame 1: draw lanes 0,2,4.
    push_op(3'd0, 1'b0); push_op(3'd2, 1'b0); push_op(3'd4, 1'b0);
    cnt_q.push_back(1);
    reset = 1'b0;
    tick();
    check("first_shift", 32'(shift_o), 32'd1);
    check("first_count", 32'(beat_count_o), 32'd1);
    start_i = 1'b0;
    repeat (30) tick();
    check("wait_busy", 32'(busy_o), 32'd1);
    check("wait_not_paused", 32'(paused_o), 32'd0);

    // Beat in WAIT: erase lanes 0,2,4 then next frame.
    push_op(3'd0, 1'b1); push_op(3'd2, 1'b1); push_op(3'd4, 1'b1);
    cnt_q.push_back(2);
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0;
    wait_shift("frame2_shift", 60);

    // Frame 2: empty lanes, pause held; WAIT 11 cycles after shift, PAUSED at 12.
    lane_active_i = 5'b00000;
    pause_i = 1'b1;
    n = 0;
    while (!paused_o && n < 40) begin
      tick();
      n++;
    end
    check("empty_wait_latency", 32'(n), 32'd12);
    check("paused_flag", 32'(paused_o), 32'd1);
    check("paused_busy", 32'(busy_o), 32'd0);
    beat_i = 1'b1; tick(); beat_i = 1'b0; tick();
    beat_i = 1'b1; tick(); beat_i = 1'b0; tick();
    check("paused_no_overrun", 32'(overrun_o), 32'd0);
    pause_i = 1'b0;
    repeat (20) tick();
    check("unpaused_busy", 32'(busy_o), 32'd1);
    check("unpaused_paused", 32'(paused_o), 32'd0);
    check("paused_beats_dropped", 32'(beat_count_o), 32'd2);

    // Beat after unpause: empty erase phase, shift 11 cycles later.
    cnt_q.push_back(3);
    beat_i = 1'b1;
    n = 0;
    while (!shift_o && n < 40) begin
      tick();
      beat_i = 1'b0;
      n++;
    end
    check("empty_erase_latency", 32'(n), 32'd11);

    // Frame 3: one beat during draw makes WAIT exit at once.
    lane_active_i = 5'b00001;
    push_op(3'd0, 1'b0); push_op(3'd0, 1'b1);
    cnt_q.push_back(4);
    beat_i = 1'b1;
    n = 0;
    while (!(plot_go_o && plot_erase_o) && n < 40) begin
      tick();
      beat_i = 1'b0;
      n++;
    end
    check("pending_exit_latency", 32'(n), 32'd17);
    check("single_beat_no_overrun", 32'(overrun_o), 32'd0);
    wait_shift("frame4_shift", 60);

    // Frame 4: two beats before WAIT -> overrun.
    push_op(3'd0, 1'b0); push_op(3'd0, 1'b1);
    cnt_q.push_back(5);
    beat_i = 1'b1; tick(); beat_i = 1'b0; tick();
    beat_i = 1'b1; tick(); beat_i = 1'b0;
    check("overrun_set", 32'(overrun_o), 32'd1);
    wait_shift("frame5_shift", 60);
    check("overrun_sticky", 32'(overrun_o), 32'd1);

    // Frame 5: stop during lane 2 op; lanes 3,4 never plotted.
    lane_active_i = 5'b11100;
    push_op(3'd2, 1'b0);
    wait_go("stop_go", 20);
    tick();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check("stop_hold_lane", 32'(lane_sel_o), 32'd2);
    check("stop_hold_erase", 32'(plot_erase_o), 32'd0);
    check("stop_hold_busy", 32'(busy_o), 32'd1);
    tick(); tick();
    check("stop_next_busy", 32'(busy_o), 32'd1);
    tick();
    check("stop_idle_busy", 32'(busy_o), 32'd0);
    repeat (10) tick();
    check("idle_overrun_kept", 32'(overrun_o), 32'd1);

    // Restart from IDLE clears overrun; reset in OP returns to IDLE.
    lane_active_i = 5'b00010;
    push_op(3'd1, 1'b0);
    cnt_q.push_back(6);
    start_i = 1'b1;
    wait_shift("restart_shift", 5);
    start_i = 1'b0;
    check("restart_overrun_clear", 32'(overrun_o), 32'd0);
    wait_go("reset_go", 10);
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("midop_reset");
    reset = 1'b0;
    repeat (6) tick();
    check("post_reset_busy", 32'(busy_o), 32'd0);
    check("post_reset_count", 32'(beat_count_o), 32'd0);

    check("ops_drained", 32'(op_q.size()), 32'd0);
    check("shifts_drained", 32'(cnt_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
